// File: rtl/palette_lut_dbuf_pkg.sv
// Shared types and helpers for the double-buffered palette lookup.
package palette_pkg;

   localparam int PAL_INDEX_W = 4;
   localparam int PAL_CH_W    = 4;

   typedef struct packed {
      logic [PAL_CH_W-1:0] red;
      logic [PAL_CH_W-1:0] green;
      logic [PAL_CH_W-1:0] blue;
   } rgb_t;

   typedef enum logic [1:0] {INIT, IDLE, PENDING, COPY} pal_state_e;

   // MSB-align an index into a channel: zero-fill below when the channel is
   // wider, keep only the top bits when it is narrower.
   function automatic logic [31:0] default_chan(input logic [31:0] idx,
                                                input int index_w,
                                                input int ch_w);
      if (ch_w >= index_w) return idx << (ch_w - index_w);
      else                 return idx >> (index_w - ch_w);
   endfunction

   // Default colour for an entry at the package's nominal widths.
   function automatic rgb_t default_rgb(input logic [PAL_INDEX_W-1:0] idx);
      rgb_t c;
      c.red   = PAL_CH_W'(default_chan(32'(idx), PAL_INDEX_W, PAL_CH_W));
      c.green = c.red;
      c.blue  = c.red;
      return c;
   endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// Two palette banks in flops: one write port, pixel and copy-source read ports.
module palette_bank_ram #(
   parameter int INDEX_W = 4,
   parameter int DATA_W  = 12
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic               wr_both,
   input  logic               wr_bank,
   input  logic [INDEX_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               px_bank,
   input  logic [INDEX_W-1:0] px_addr,
   output logic [DATA_W-1:0]  px_data,
   input  logic               cp_bank,
   input  logic [INDEX_W-1:0] cp_addr,
   output logic [DATA_W-1:0]  cp_data
);
   localparam int ENTRIES = 1 << INDEX_W;

   logic [DATA_W-1:0] mem_q [2][ENTRIES];

   // wr_both lets the init sweep fill both banks in a single pass
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_both || !wr_bank) mem_q[1'b0][wr_addr] <= wr_data;
         if (wr_both ||  wr_bank) mem_q[1'b1][wr_addr] <= wr_data;
      end
   end

   assign px_data = mem_q[px_bank][px_addr];
   assign cp_data = mem_q[cp_bank][cp_addr];

endmodule

// File: rtl/palette_lut_dbuf.sv
// Palette lookup with active/shadow banks; commits publish at frame boundaries.
module palette_lut_dbuf
   import palette_pkg::*;
#(
   parameter int INDEX_W    = 4,
   parameter int CH_W       = 4,
   parameter int TRANSP_IDX = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               px_valid_in,
   input  logic [INDEX_W-1:0] px_index,
   output logic               px_valid_out,
   output logic [CH_W-1:0]    px_red,
   output logic [CH_W-1:0]    px_green,
   output logic [CH_W-1:0]    px_blue,
   output logic               px_transp,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_addr,
   input  logic [3*CH_W-1:0]  wr_data,
   output logic               wr_ready,
   input  logic               commit,
   input  logic               frame_start,
   output logic               busy,
   output logic               swap_pulse
);
   localparam int RGB_W = 3 * CH_W;
   localparam logic [INDEX_W-1:0] LAST = INDEX_W'((1 << INDEX_W) - 1);
   localparam logic [INDEX_W-1:0] TIDX = INDEX_W'(TRANSP_IDX);

   pal_state_e         state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;
   logic               active_q, active_d;
   logic               wr_ready_q, wr_ready_d;
   logic               busy_q, busy_d;
   logic               swap_q, swap_d;

   logic               ram_we, ram_both, ram_bank;
   logic [INDEX_W-1:0] ram_addr;
   logic [RGB_W-1:0]   ram_wdata, px_rdata, cp_rdata, init_rgb;
   logic [CH_W-1:0]    init_chan;

   logic               s1_vld_q, s1_vld_d, s1_bank_q, s1_bank_d, s1_zero_q, s1_zero_d;
   logic [INDEX_W-1:0] s1_idx_q, s1_idx_d;
   logic               s2_vld_q, s2_vld_d, s2_transp_q, s2_transp_d;
   logic [RGB_W-1:0]   s2_rgb_q, s2_rgb_d;

   assign init_chan = CH_W'(default_chan(32'(cnt_q), INDEX_W, CH_W));
   assign init_rgb  = {3{init_chan}};

   palette_bank_ram #(.INDEX_W(INDEX_W), .DATA_W(RGB_W)) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_both (ram_both),
      .wr_bank (ram_bank),
      .wr_addr (ram_addr),
      .wr_data (ram_wdata),
      .px_bank (s1_bank_q),
      .px_addr (s1_idx_q),
      .px_data (px_rdata),
      .cp_bank (active_q),
      .cp_addr (cnt_q),
      .cp_data (cp_rdata)
   );

   // Sequencer: init sweep, host writes to shadow, frame-aligned flip, shadow resync
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      swap_d    = 1'b0;
      ram_we    = 1'b0;
      ram_both  = 1'b0;
      ram_bank  = ~active_q;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      case (state_q)
         INIT: begin
            ram_we    = 1'b1;
            ram_both  = 1'b1;
            ram_addr  = cnt_q;
            ram_wdata = init_rgb;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         IDLE: begin
            ram_we = wr_en;
            if (commit) state_d = PENDING;
         end
         PENDING: begin
            if (frame_start) begin
               active_d = ~active_q;
               cnt_d    = '0;
               swap_d   = 1'b1;
               state_d  = COPY;
            end
         end
         COPY: begin
            // active_q is already the new bank; refresh the old one from it
            ram_we    = 1'b1;
            ram_addr  = cnt_q;
            ram_wdata = cp_rdata;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
      wr_ready_d = (state_d == IDLE);
      busy_d     = (state_d == INIT) || (state_d == COPY);
   end

   // Two-stage lookup; the bank is frozen at stage 1 so a flip never splits a pixel
   always_comb begin
      s1_vld_d    = px_valid_in;
      s1_idx_d    = px_index;
      s1_bank_d   = active_q;
      s1_zero_d   = (state_q == INIT);
      s2_vld_d    = s1_vld_q;
      s2_rgb_d    = (s1_vld_q && !s1_zero_q) ? px_rdata : '0;
      s2_transp_d = s1_vld_q && (s1_idx_q == TIDX);
   end

   // State and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         active_q    <= 1'b0;
         wr_ready_q  <= 1'b0;
         busy_q      <= 1'b1;
         swap_q      <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_idx_q    <= '0;
         s1_bank_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s2_vld_q    <= 1'b0;
         s2_rgb_q    <= '0;
         s2_transp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         wr_ready_q  <= wr_ready_d;
         busy_q      <= busy_d;
         swap_q      <= swap_d;
         s1_vld_q    <= s1_vld_d;
         s1_idx_q    <= s1_idx_d;
         s1_bank_q   <= s1_bank_d;
         s1_zero_q   <= s1_zero_d;
         s2_vld_q    <= s2_vld_d;
         s2_rgb_q    <= s2_rgb_d;
         s2_transp_q <= s2_transp_d;
      end
   end

   assign px_valid_out = s2_vld_q;
   assign px_red       = s2_rgb_q[RGB_W-1 -: CH_W];
   assign px_green     = s2_rgb_q[2*CH_W-1 -: CH_W];
   assign px_blue      = s2_rgb_q[CH_W-1:0];
   assign px_transp    = s2_transp_q;
   assign wr_ready     = wr_ready_q;
   assign busy         = busy_q;
   assign swap_pulse   = swap_q;

endmodule

// File: tb/tb_palette_lut_dbuf.sv
// Bench for palette_lut_dbuf: directed palette scenarios plus randomized traffic
// checked every cycle against a displayed/shadow palette model.
module tb_palette_lut_dbuf;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        px_valid_in = 1'b0;
   logic [3:0]  px_index = '0;
   logic        px_valid_out, px_transp, wr_ready, busy, swap_pulse;
   logic [3:0]  px_red, px_green, px_blue;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic        commit = 1'b0;
   logic        frame_start = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   palette_lut_dbuf #(.INDEX_W(4), .CH_W(4), .TRANSP_IDX(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .px_valid_in(px_valid_in), .px_index(px_index),
      .px_valid_out(px_valid_out), .px_red(px_red), .px_green(px_green),
      .px_blue(px_blue), .px_transp(px_transp),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .commit(commit), .frame_start(frame_start),
      .busy(busy), .swap_pulse(swap_pulse)
   );

   // ---------------- model: what is on screen, what is staged ----------------
   logic [11:0] disp [N];
   logic [11:0] shad [N];
   int          mode;   // 0 init, 1 idle, 2 pending, 3 copy
   int          mcnt;
   logic        s1_v, s1_t, e_v, e_t, e_busy, e_rdy, e_swap;
   logic [11:0] s1_c, e_c;

   function automatic logic [11:0] dflt(input int i);
      logic [3:0] v;
      v = 4'(i);
      return {v, v, v};
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         mode = 0; mcnt = 0;
         s1_v = 0; s1_t = 0; s1_c = '0;
         e_v = 0; e_t = 0; e_c = '0;
         e_busy = 1; e_rdy = 0; e_swap = 0;
         for (int i = 0; i < N; i++) begin
            disp[i] = dflt(i);
            shad[i] = dflt(i);
         end
         return;
      end
      e_v = s1_v; e_t = s1_t; e_c = s1_c;
      s1_v = px_valid_in;
      s1_t = px_valid_in && (px_index == 4'd0);
      s1_c = (px_valid_in && mode != 0) ? disp[px_index] : 12'h000;
      e_swap = 0;
      case (mode)
         0: begin mcnt++; if (mcnt == N) mode = 1; end
         1: begin
            if (wr_en) shad[wr_addr] = wr_data;
            if (commit) mode = 2;
         end
         2: if (frame_start) begin
            for (int i = 0; i < N; i++) disp[i] = shad[i];
            mode = 3; mcnt = 0; e_swap = 1;
         end
         default: begin mcnt++; if (mcnt == N) mode = 1; end
      endcase
      e_busy = (mode == 0) || (mode == 3);
      e_rdy  = (mode == 1);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // every-cycle comparison against the model
   initial forever begin
      @(posedge clk);
      #1;
      chk("cyc valid", 32'(px_valid_out), 32'(e_v));
      chk("cyc rgb", 32'({px_red, px_green, px_blue}), 32'(e_c));
      chk("cyc transp", 32'(px_transp), 32'(e_t));
      chk("cyc busy", 32'(busy), 32'(e_busy));
      chk("cyc wr_ready", 32'(wr_ready), 32'(e_rdy));
      chk("cyc swap", 32'(swap_pulse), 32'(e_swap));
   end

   // ---------------- directed helpers ----------------
   task automatic lookup(input string nm, input logic [3:0] idx,
                         input logic [11:0] exp_c, input logic exp_t);
      @(negedge clk); px_valid_in = 1'b1; px_index = idx;
      @(negedge clk); px_valid_in = 1'b0;
      @(posedge clk); #1;
      chk({nm, " valid"}, 32'(px_valid_out), 32'd1);
      chk({nm, " rgb"}, 32'({px_red, px_green, px_blue}), 32'(exp_c));
      chk({nm, " transp"}, 32'(px_transp), 32'(exp_t));
   endtask

   task automatic write(input string nm, input logic [3:0] a, input logic [11:0] d,
                        input logic exp_rdy);
      @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
      chk({nm, " wr_ready"}, 32'(wr_ready), 32'(exp_rdy));
      @(negedge clk); wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      @(negedge clk); commit = 1'b1;
      @(negedge clk); commit = 1'b0;
   endtask

   task automatic pulse_fs();
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int exp_cycles);
      int n;
      n = 0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         n++;
         if (wr_ready) break;
      end
      chk({nm, " ready"}, 32'(wr_ready), 32'd1);
      chk({nm, " cycles"}, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst valid", 32'(px_valid_out), 32'd0);
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst wr_ready", 32'(wr_ready), 32'd0);
      chk("rst swap", 32'(swap_pulse), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wait_idle("init", 16);

      lookup("idx5", 4'd5, 12'h555, 1'b0);
      lookup("idx0", 4'd0, 12'h000, 1'b1);

      write("w3", 4'd3, 12'hF00, 1'b1);
      lookup("pre3", 4'd3, 12'h333, 1'b0);
      repeat (3) begin pulse_fs(); repeat (2) @(negedge clk); end
      lookup("nocommit3", 4'd3, 12'h333, 1'b0);

      pulse_commit();
      pulse_fs();
      chk("swap pulse", 32'(swap_pulse), 32'd1);
      chk("copy busy", 32'(busy), 32'd1);
      wait_idle("copy1", 16);
      lookup("post3", 4'd3, 12'hF00, 1'b0);

      pulse_commit();
      write("pend7", 4'd7, 12'h0F0, 1'b0);
      pulse_fs();
      wait_idle("copy2", 16);
      lookup("ign7", 4'd7, 12'h777, 1'b0);

      write("w9", 4'd9, 12'h00F, 1'b1);
      pulse_commit();
      pulse_fs();
      wait_idle("copy3", 16);
      lookup("keep3", 4'd3, 12'hF00, 1'b0);
      lookup("new9", 4'd9, 12'h00F, 1'b0);

      pulse_commit();
      pulse_fs();
      px_valid_in = 1'b1; px_index = 4'd3;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort valid", 32'(px_valid_out), 32'd0);
      chk("abort rgb", 32'({px_red, px_green, px_blue}), 32'd0);
      chk("abort busy", 32'(busy), 32'd1);
      chk("abort wr_ready", 32'(wr_ready), 32'd0);
      px_valid_in = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      wait_idle("reinit", 16);
      lookup("reset3", 4'd3, 12'h333, 1'b0);

      // randomized traffic, including commits during init/copy and rare resets
      repeat (4000) begin
         @(negedge clk);
         px_valid_in = 1'($urandom_range(0, 1));
         px_index    = 4'($urandom);
         wr_en       = ($urandom_range(0, 2) == 0);
         wr_addr     = 4'($urandom);
         wr_data     = 12'($urandom);
         commit      = ($urandom_range(0, 11) == 0);
         frame_start = ($urandom_range(0, 24) == 0);
         rst_n       = ($urandom_range(0, 699) != 0);
      end
      @(negedge clk);
      px_valid_in = 1'b0; wr_en = 1'b0; commit = 1'b0; frame_start = 1'b0; rst_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
